// File: rtl/icache_dm_if.sv
// icache_dm_if
//    Bundles the two buses of the direct-mapped instruction cache.
//    Fetch side : cache_addr, cache_rd, invalidate -> cache
//                 cache_data, cache_waitrequest    <- cache
//    Memory side: mem_addr, mem_rd                 <- cache
//                 mem_waitrequest, mem_rddata,
//                 mem_rddatavalid                  -> cache
//    modport slave  : the cache itself
//    modport master : the environment (fetch stage plus memory/arbiter)
`timescale 1ns/1ps
interface icache_dm_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int MEM_WIDTH  = 32
);
   logic [ADDR_WIDTH-1:0] cache_addr;
   logic                  cache_rd;
   logic [DATA_WIDTH-1:0] cache_data;
   logic                  cache_waitrequest;
   logic                  invalidate;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic                  mem_waitrequest;
   logic [MEM_WIDTH-1:0]  mem_rddata;
   logic                  mem_rddatavalid;

   modport slave (
      input  cache_addr, cache_rd, invalidate,
      input  mem_waitrequest, mem_rddata, mem_rddatavalid,
      output cache_data, cache_waitrequest,
      output mem_addr, mem_rd
   );

   modport master (
      output cache_addr, cache_rd, invalidate,
      output mem_waitrequest, mem_rddata, mem_rddatavalid,
      input  cache_data, cache_waitrequest,
      input  mem_addr, mem_rd
   );
endinterface

// File: rtl/icache_dm.sv
// icache_dm
//    Direct-mapped, read-only instruction cache between the fetch stage and
//    instruction memory. Hits return the whole 128-bit line in the request
//    cycle; misses stall fetch (cache_waitrequest) while four 32-bit beats
//    are fetched and the line is installed.
//    Ports:
//       clock   : clock
//       reset_n : synchronous active-low reset
//       bus     : icache_dm_if.slave (fetch port + refill port)
`timescale 1ns/1ps
module icache_dm #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int MEM_WIDTH  = 32,
   parameter int NUM_LINES  = 64
) (
   input logic        clock,
   input logic        reset_n,
   icache_dm_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_WIDTH - 4 - IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

   state_t                  state_reg, state_next;
   logic [1:0]              beat_reg;
   logic [ADDR_WIDTH-1:0]   miss_addr_reg;
   logic [DATA_WIDTH-1:0]   line_buf_reg;
   logic [NUM_LINES-1:0]    valid_reg;
   logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
   logic [DATA_WIDTH-1:0]   data_mem [NUM_LINES];

   logic [IDX_W-1:0]        lookup_idx, miss_idx;
   logic [TAG_W-1:0]        lookup_tag, miss_tag;
   logic                    hit;
   logic                    miss_start;
   logic                    beat_done;
   logic                    fill_en;
   logic                    unused_offset;

   // The byte offset within a line never affects lookup.
   assign unused_offset = ^bus.cache_addr[3:0];

   assign lookup_idx = bus.cache_addr[4 +: IDX_W];
   assign lookup_tag = bus.cache_addr[ADDR_WIDTH-1 -: TAG_W];
   assign miss_idx   = miss_addr_reg[4 +: IDX_W];
   assign miss_tag   = miss_addr_reg[ADDR_WIDTH-1 -: TAG_W];

   // Lookups only hit while idle, so a same-index FILL cycle reads as a miss.
   assign hit = (state_reg == IDLE) && valid_reg[lookup_idx] &&
                (tag_mem[lookup_idx] == lookup_tag);

   assign bus.cache_waitrequest = bus.cache_rd & ~hit;
   assign bus.cache_data        = data_mem[lookup_idx];

   // Refill request is decoded from state; miss_addr is line aligned, so the
   // beat offset can be OR-ed into bits [3:2].
   assign bus.mem_rd   = (state_reg == REQ);
   assign bus.mem_addr = (state_reg == REQ) ?
                         (miss_addr_reg | {{(ADDR_WIDTH-4){1'b0}}, beat_reg, 2'b00}) :
                         '0;

   always_comb begin
      state_next = state_reg;
      miss_start = 1'b0;
      beat_done  = 1'b0;
      fill_en    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.cache_rd && !hit && !bus.invalidate) begin
               miss_start = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (!bus.mem_waitrequest) state_next = WAIT;
         end
         WAIT: begin
            if (bus.mem_rddatavalid) begin
               beat_done  = 1'b1;
               state_next = (beat_reg == 2'd3) ? FILL : REQ;
            end
         end
         FILL: begin
            fill_en    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         beat_reg      <= 2'd0;
         miss_addr_reg <= '0;
         line_buf_reg  <= '0;
         valid_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (miss_start) begin
            miss_addr_reg <= {bus.cache_addr[ADDR_WIDTH-1:4], 4'b0000};
            beat_reg      <= 2'd0;
         end
         // Beats arrive in address order and word 0 lives in the MSBs, so
         // shifting left assembles the line with beat 0 on top after 4 beats.
         if (beat_done) begin
            line_buf_reg <= {line_buf_reg[DATA_WIDTH-MEM_WIDTH-1:0], bus.mem_rddata};
            if (beat_reg != 2'd3) beat_reg <= beat_reg + 2'd1;
         end
         // Invalidate beats a coincident fill: that line stays invalid.
         if (bus.invalidate)  valid_reg           <= '0;
         else if (fill_en)    valid_reg[miss_idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; a reset during FILL drops the line.
   always_ff @(posedge clock) begin
      if (reset_n && fill_en) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= line_buf_reg;
      end
   end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm
//    Self-checking bench for icache_dm: directed scenarios followed by
//    randomized reads, checked against a line-level model of the cache
//    contents and a behavioural memory responder.
`timescale 1ns/1ps
module tb_icache_dm;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   icache_dm_if bus ();

   icache_dm dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // model: which line base address each index currently holds
   bit          mvalid [64];
   logic [31:0] mbase  [64];

   // responder state
   logic [31:0] acc_q [$];
   logic [31:0] stall_addr = 32'h0;
   int          stall_left = 0;
   bit          rand_stall = 1'b0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   bit          hold_prev = 1'b0;
   logic [31:0] hold_addr = 32'h0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'h11;
         32'h104: return 32'h22;
         32'h108: return 32'h33;
         32'h10C: return 32'h44;
         default: return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
      endcase
   endfunction

   function automatic logic [127:0] line_of(input logic [31:0] base);
      return {mem_word(base), mem_word(base + 32'd4), mem_word(base + 32'd8), mem_word(base + 32'd12)};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
   endtask

   // Memory: accepts a beat when mem_rd & ~mem_waitrequest, returns it the next cycle.
   initial begin
      bus.mem_waitrequest = 1'b0;
      bus.mem_rddatavalid = 1'b0;
      bus.mem_rddata      = 32'h0;
      forever begin
         @(posedge clock); #1;
         bus.mem_rddatavalid = pend;
         bus.mem_rddata      = pend ? mem_word(pend_addr) : $urandom;
         pend = 1'b0;
         if (bus.mem_rd && stall_left > 0 && bus.mem_addr == stall_addr) begin
            bus.mem_waitrequest = 1'b1;
            stall_left--;
         end else if (rand_stall && bus.mem_rd)
            bus.mem_waitrequest = ($urandom_range(0, 2) == 0);
         else
            bus.mem_waitrequest = 1'b0;
      end
   end

   always @(negedge clock) begin
      if (hold_prev) begin
         check("stall_hold_rd", 128'(bus.mem_rd), 128'(1));
         check("stall_hold_addr", 128'(bus.mem_addr), 128'(hold_addr));
      end
      hold_prev = reset_n && bus.mem_rd && bus.mem_waitrequest;
      hold_addr = bus.mem_addr;
      if (reset_n && bus.mem_rd && !bus.mem_waitrequest) begin
         acc_q.push_back(bus.mem_addr);
         pend      = 1'b1;
         pend_addr = bus.mem_addr;
      end
   end

   // One read transaction. exp_lat < 0 skips the latency check; inv_cycle
   // (1-based, cycle 1 = request cycle) pulses invalidate during the refill.
   task automatic do_read(input logic [31:0] addr, input int exp_lat, input int inv_cycle);
      logic [31:0] base;
      logic [5:0]  idx;
      bit          exp_hit;
      int          n;
      int          reps;
      base    = {addr[31:4], 4'h0};
      idx     = addr[9:4];
      exp_hit = mvalid[idx] && (mbase[idx] == base);
      @(posedge clock); #1;
      bus.cache_addr = addr;
      bus.cache_rd   = 1'b1;
      acc_q.delete();
      @(negedge clock);
      check("first_wait", 128'(bus.cache_waitrequest), 128'(exp_hit ? 0 : 1));
      if (exp_hit) begin
         check("hit_data", bus.cache_data, line_of(base));
         check("hit_no_memrd", 128'(bus.mem_rd), 128'(0));
         $display("read %h hit", addr);
      end else begin
         for (n = 1; n <= 200; n++) begin
            @(posedge clock); #1;
            bus.invalidate = (n + 1 == inv_cycle);
            @(negedge clock);
            if (!bus.cache_waitrequest) break;
         end
         bus.invalidate = 1'b0;
         if (n > 200) check("wait_bound", 128'(bus.cache_waitrequest), 128'(0));
         else begin
            if (exp_lat >= 0) check("miss_latency", 128'(n), 128'(exp_lat));
            check("fill_data", bus.cache_data, line_of(base));
            check("fill_no_memrd", 128'(bus.mem_rd), 128'(0));
            reps = (inv_cycle == 10) ? 2 : 1;
            check("beat_count", 128'(acc_q.size()), 128'(4 * reps));
            for (int k = 0; k < acc_q.size() && k < 4 * reps; k++)
               check("beat_addr", 128'(acc_q[k]), 128'(base + 32'(4 * (k % 4))));
         end
         if (inv_cycle > 0) model_clear();
         mvalid[idx] = 1'b1;
         mbase[idx]  = base;
         $display("read %h miss, latency %0d, beats %0d", addr, n, acc_q.size());
      end
   endtask

   task automatic pulse_inv();
      @(posedge clock); #1;
      bus.cache_rd   = 1'b0;
      bus.invalidate = 1'b1;
      @(posedge clock); #1;
      bus.invalidate = 1'b0;
      model_clear();
      $display("invalidate pulse");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      model_clear();
      bus.cache_addr = $urandom;
      bus.cache_rd   = 1'b1;
      bus.invalidate = 1'b0;

      // reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_wait", 128'(bus.cache_waitrequest), 128'(1));
      check("reset_memrd", 128'(bus.mem_rd), 128'(0));
      check("reset_memaddr", 128'(bus.mem_addr), 128'(0));
      @(posedge clock); #1;
      bus.cache_rd = 1'b0;
      @(negedge clock);
      check("reset_idle_wait", 128'(bus.cache_waitrequest), 128'(0));
      @(posedge clock); #1;
      reset_n = 1'b1;
      $display("reset released");

      // cold miss, then hit, then explicit line value
      do_read(32'h100, 10, 0);
      check("cold_line", bus.cache_data, 128'h00000011_00000022_00000033_00000044);
      do_read(32'h108, -1, 0);

      // conflict on index 16
      do_read(32'h500, 10, 0);
      do_read(32'h100, 10, 0);

      // invalidate then full refill
      pulse_inv();
      do_read(32'h100, 10, 0);

      // memory stalls on beat 2
      pulse_inv();
      stall_addr = 32'h108;
      stall_left = 3;
      do_read(32'h100, 13, 0);

      // invalidate in IDLE suppresses the miss
      @(posedge clock); #1;
      bus.cache_addr = 32'h900;
      bus.cache_rd   = 1'b1;
      bus.invalidate = 1'b1;
      @(negedge clock);
      check("inv_idle_wait", 128'(bus.cache_waitrequest), 128'(1));
      @(posedge clock); #1;
      bus.cache_rd   = 1'b0;
      bus.invalidate = 1'b0;
      model_clear();
      @(negedge clock);
      check("inv_suppress_memrd", 128'(bus.mem_rd), 128'(0));
      $display("invalidate with request: no refill");

      // invalidate during refill: line still installed, others dropped
      do_read(32'h100, 10, 0);
      do_read(32'h300, 10, 4);
      do_read(32'h100, 10, 0);
      do_read(32'h300, -1, 0);
      // invalidate in the FILL cycle: line dropped, refilled again
      do_read(32'h700, 20, 10);
      do_read(32'h704, -1, 0);

      // reset mid-refill
      pulse_inv();
      @(posedge clock); #1;
      bus.cache_addr = 32'h100;
      bus.cache_rd   = 1'b1;
      repeat (5) @(posedge clock);
      @(negedge clock);
      check("rst_beat2_rd", 128'(bus.mem_rd), 128'(1));
      check("rst_beat2_addr", 128'(bus.mem_addr), 128'(32'h108));
      reset_n = 1'b0;
      @(negedge clock);
      check("rst_mid_memrd", 128'(bus.mem_rd), 128'(0));
      check("rst_mid_memaddr", 128'(bus.mem_addr), 128'(0));
      check("rst_mid_wait", 128'(bus.cache_waitrequest), 128'(1));
      @(posedge clock); #1;
      reset_n      = 1'b1;
      bus.cache_rd = 1'b0;
      model_clear();
      $display("reset during refill");
      do_read(32'h100, 10, 0);

      // randomized reads over a small address pool with random stalls
      rand_stall = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) pulse_inv();
         else begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
                32'($urandom_range(0, 15));
            do_read(a, -1, 0);
         end
      end
      rand_stall = 1'b0;

      @(posedge clock); #1;
      bus.cache_rd = 1'b0;
      repeat (2) @(posedge clock);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
